// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard query and the scoreboard's stall/forward answer, bundled between
// the decode control unit (master) and the scoreboard (slave).
interface hazard_scoreboard_if #(
    parameter int RA_W  = 5,
    parameter int T_W   = 2,
    parameter int CNT_W = 32
);
    logic [RA_W-1:0]  rs_d;
    logic [RA_W-1:0]  rt_d;
    logic [T_W-1:0]   tuse_rs_d;
    logic [T_W-1:0]   tuse_rt_d;
    logic             wr_d;
    logic [RA_W-1:0]  dst_d;
    logic [T_W-1:0]   tnew_d;
    logic             stall;
    logic             bubble_e;
    logic [1:0]       fwd_rs_d;
    logic [1:0]       fwd_rt_d;
    logic [1:0]       fwd_rs_e;
    logic [1:0]       fwd_rt_e;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output rs_d, rt_d, tuse_rs_d, tuse_rt_d, wr_d, dst_d, tnew_d,
        input  stall, bubble_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, stall_cnt
    );
    modport slave (
        input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, wr_d, dst_d, tnew_d,
        output stall, bubble_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Stall/forward controller: tracks {valid, dst, remaining Tnew} for E/M/W and
// resolves D-stage operand hazards by stalling or selecting a forwarding source.
module hazard_scoreboard #(
    parameter int RA_W  = 5,
    parameter int T_W   = 2,
    parameter int CNT_W = 32
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave bus
);
    localparam logic [T_W-1:0] TUSE_NONE = '1;

    typedef struct packed {
        logic            v;
        logic [RA_W-1:0] dst;
        logic [T_W-1:0]  tnew;
    } ent_t;

    ent_t             r_e, r_m, r_w;
    logic [RA_W-1:0]  r_rs_e, r_rt_e;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_stall;

    function automatic logic match(input ent_t s, input logic [RA_W-1:0] r);
        return s.v && (s.dst == r) && (r != '0);
    endfunction

    function automatic logic [T_W-1:0] sat0(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    function automatic logic op_stall(input logic [RA_W-1:0] r, input logic [T_W-1:0] tuse);
        return (tuse != TUSE_NONE) &&
               ((match(r_e, r) && (r_e.tnew > tuse)) || (match(r_m, r) && (r_m.tnew > tuse)));
    endfunction

    // D select may point at a producer not yet ready; the stall masks that case.
    function automatic logic [1:0] fwd_d(input logic [RA_W-1:0] r);
        if (match(r_e, r)) return 2'd1;
        if (match(r_m, r)) return 2'd2;
        if (match(r_w, r)) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [RA_W-1:0] r);
        if (match(r_m, r)) return 2'd2;
        if (match(r_w, r)) return 2'd3;
        return 2'd0;
    endfunction

    assign w_stall = op_stall(bus.rs_d, bus.tuse_rs_d) || op_stall(bus.rt_d, bus.tuse_rt_d);

    assign bus.stall     = w_stall;
    assign bus.bubble_e  = w_stall;
    assign bus.fwd_rs_d  = fwd_d(bus.rs_d);
    assign bus.fwd_rt_d  = fwd_d(bus.rt_d);
    assign bus.fwd_rs_e  = fwd_e(r_rs_e);
    assign bus.fwd_rt_e  = fwd_e(r_rt_e);
    assign bus.stall_cnt = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_e         <= '0;
            r_m         <= '0;
            r_w         <= '0;
            r_rs_e      <= '0;
            r_rt_e      <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_w <= '{v: r_m.v, dst: r_m.dst, tnew: sat0(r_m.tnew)};
            r_m <= '{v: r_e.v, dst: r_e.dst, tnew: sat0(r_e.tnew)};
            if (w_stall) begin
                r_e    <= '0;
                r_rs_e <= '0;
                r_rt_e <= '0;
                if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
            end else begin
                r_e    <= '{v: bus.wr_d && (bus.dst_d != '0), dst: bus.dst_d, tnew: bus.tnew_d};
                r_rs_e <= bus.rs_d;
                r_rt_e <= bus.rt_d;
            end
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed pipeline scenarios plus randomized traffic, checked each cycle against
// an age-based model of the last three issued instructions.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.RA_W(5), .T_W(2), .CNT_W(32)) bus ();
    hazard_scoreboard #(.RA_W(5), .T_W(2), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    // hist[0] is the instruction now in E, hist[1] in M, hist[2] in W
    typedef struct {
        bit v;
        int dst;
        int tnew0;
        int rs;
        int rt;
    } instr_t;

    instr_t hist[3];
    int unsigned m_cnt;
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic int remaining(input int age);
        return (hist[age].tnew0 > age) ? hist[age].tnew0 - age : 0;
    endfunction

    function automatic bit hit(input int age, input int r);
        return hist[age].v && hist[age].dst == r && r != 0;
    endfunction

    function automatic bit m_stall(input int r, input int tuse);
        if (tuse == 3) return 0;
        for (int a = 0; a < 2; a++)
            if (hit(a, r) && remaining(a) > tuse) return 1;
        return 0;
    endfunction

    function automatic int m_fwd_d(input int r);
        for (int a = 0; a < 3; a++) if (hit(a, r)) return a + 1;
        return 0;
    endfunction

    function automatic int m_fwd_e(input int r);
        for (int a = 1; a < 3; a++) if (hit(a, r)) return a + 1;
        return 0;
    endfunction

    function automatic void model_clear();
        for (int a = 0; a < 3; a++) hist[a] = '{0, 0, 0, 0, 0};
        m_cnt = 0;
    endfunction

    // Apply one D-stage instruction for one cycle, check outputs, then clock.
    task automatic step(input int rs, input int rt, input int tur, input int tut,
                        input bit wr, input int dst, input int tnew, input bit rst);
        bit st;
        instr_t nw;
        @(negedge clk);
        bus.rs_d = 5'(rs); bus.rt_d = 5'(rt);
        bus.tuse_rs_d = 2'(tur); bus.tuse_rt_d = 2'(tut);
        bus.wr_d = wr; bus.dst_d = 5'(dst); bus.tnew_d = 2'(tnew);
        reset = rst;
        #1;
        st = m_stall(rs, tur) || m_stall(rt, tut);
        chk("stall", 32'(bus.stall), 32'(st));
        chk("bubble_e", 32'(bus.bubble_e), 32'(st));
        chk("fwd_rs_d", 32'(bus.fwd_rs_d), 32'(m_fwd_d(rs)));
        chk("fwd_rt_d", 32'(bus.fwd_rt_d), 32'(m_fwd_d(rt)));
        chk("fwd_rs_e", 32'(bus.fwd_rs_e), 32'(m_fwd_e(hist[0].rs)));
        chk("fwd_rt_e", 32'(bus.fwd_rt_e), 32'(m_fwd_e(hist[0].rt)));
        chk("stall_cnt", bus.stall_cnt, m_cnt);
        @(posedge clk);
        if (rst) model_clear();
        else begin
            nw = st ? '{0, 0, 0, 0, 0} : '{wr && dst != 0, dst, tnew, rs, rt};
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = nw;
            if (st && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        end
    endtask

    initial begin
        model_clear();
        bus.rs_d = '0; bus.rt_d = '0; bus.tuse_rs_d = 2'd3; bus.tuse_rt_d = 2'd3;
        bus.wr_d = 0; bus.dst_d = '0; bus.tnew_d = '0;
        reset = 1;
        step(0, 0, 3, 3, 0, 0, 0, 1);
        step(0, 0, 3, 3, 0, 0, 0, 1);
        // lw $1 then addu $3,$1,$2 held while stalled
        step(4, 0, 1, 3, 1, 1, 2, 0);
        repeat (3) step(1, 2, 1, 1, 1, 3, 1, 0);
        // lw $1 then beq $1,$0 (tuse 0)
        step(4, 0, 1, 3, 1, 1, 2, 0);
        repeat (4) step(1, 0, 0, 0, 0, 0, 0, 0);
        // ori $2 then beq $2,$2
        step(0, 0, 1, 3, 1, 2, 1, 0);
        repeat (3) step(2, 2, 0, 0, 0, 0, 0, 0);
        // jal then jr $31
        step(0, 0, 3, 3, 1, 31, 0, 0);
        step(31, 0, 0, 3, 0, 0, 0, 0);
        // writes to $0 never hazard
        step(4, 0, 1, 3, 1, 0, 2, 0);
        repeat (2) step(0, 0, 0, 0, 1, 0, 2, 0);
        // reset mid-stall
        step(4, 0, 1, 3, 1, 1, 2, 0);
        step(1, 2, 1, 1, 1, 3, 1, 1);
        step(1, 2, 1, 1, 1, 3, 1, 0);
        // randomized traffic on a small register window to force frequent hazards
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                 $urandom_range(0, 3), ($urandom_range(0, 99) == 0));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
